// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by a small amount (at most one
// STEP) using the requested operation. SRA takes its fill bit from the caller.
module shift_step
  import shift_pkg::*;
#(
  parameter int  WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   value,
  input  shift_op_e          op,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               fill,
  output logic [WIDTH-1:0]   shifted
);

  logic [SHAMT_W-1:0] ror_back;
  logic [WIDTH-1:0]   fill_mask;

  // Rotating right by n equals (v >> n) | (v << (WIDTH-n)); taking WIDTH-n
  // modulo WIDTH keeps a zero amount from shifting everything out.
  always_comb begin
    ror_back  = -amount;
    fill_mask = fill ? ~({WIDTH{1'b1}} >> amount) : '0;
    shifted   = value;
    case (op)
      SH_SLL: shifted = value << amount;
      SH_SRL: shifted = value >> amount;
      SH_SRA: shifted = (value >> amount) | fill_mask;
      SH_ROR: shifted = (value >> amount) | (value << ror_back);
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle barrel-shifter replacement: shifts at most STEP bits per clock
// and reports completion with a one-cycle done pulse.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int  WIDTH   = 32,
  parameter int  STEP    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

  state_e             state, next_state;
  shift_op_e          op_q, step_op;
  logic               sign_q, step_fill, accept;
  logic [SHAMT_W-1:0] remaining, step_rem, step_amt, rem_next;
  logic [WIDTH-1:0]   step_in, step_out;

  assign accept = start && (state != SHIFT);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  // The accepting edge already performs the first step on data_in, so done
  // lands max(1, ceil(shamt/STEP)) cycles after start and shamt <= STEP is
  // a single-cycle operation.
  always_comb begin
    step_in   = result;
    step_op   = op_q;
    step_fill = sign_q;
    step_rem  = remaining;
    if (accept) begin
      step_in   = data_in;
      step_op   = shift_op_e'(op);
      step_fill = data_in[WIDTH-1];
      step_rem  = shamt;
    end
    step_amt = ({1'b0, step_rem} < STEP_W) ? step_rem : STEP_W[SHAMT_W-1:0];
    rem_next = step_rem - step_amt;
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value   (step_in),
    .op      (step_op),
    .amount  (step_amt),
    .fill    (step_fill),
    .shifted (step_out)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (rem_next == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_next == '0) next_state = DONE;
      DONE:    next_state = accept ? ((rem_next == '0) ? DONE : SHIFT) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // result doubles as the accumulator; it only moves on acceptance or in SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      remaining <= '0;
      op_q      <= SH_SLL;
      sign_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept || state == SHIFT) begin
        result    <= step_out;
        remaining <= rem_next;
      end
      if (accept) begin
        op_q   <= shift_op_e'(op);
        sign_q <= data_in[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: three instances (STEP 1, 4, 32) driven from a vector
// table, hand-written corner sequences and random operations against a model.
module tb_iter_shifter;

  typedef struct {
    int          d;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  sh;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  logic        clk, reset;
  logic [2:0]  start_v, busy_v, done_v;
  logic [1:0]  op_r;
  logic [31:0] data_r;
  logic [4:0]  shamt_r;
  logic [31:0] res_v [3];
  int          vectors, miscompares;
  vec_t        table_v [11];

  iter_shifter #(.WIDTH(32), .STEP(1)) dut_s1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op_r), .data_in(data_r),
    .shamt(shamt_r), .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]));
  iter_shifter #(.WIDTH(32), .STEP(4)) dut_s4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op_r), .data_in(data_r),
    .shamt(shamt_r), .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]));
  iter_shifter #(.WIDTH(32), .STEP(32)) dut_s32 (
    .clk(clk), .reset(reset), .start(start_v[2]), .op(op_r), .data_in(data_r),
    .shamt(shamt_r), .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stepOf(input int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] x, input int s);
    logic [31:0] v = x;
    case (op)
      2'b00:   v = x << s;
      2'b01:   v = x >> s;
      2'b10:   v = 32'($signed(x) >>> s);
      default: for (int i = 0; i < s; i++) v = {v[0], v[31:1]};
    endcase
    return v;
  endfunction

  function automatic int refLatency(input int s, input int step);
    return (s == 0) ? 1 : (s + step - 1) / step;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a sample point; returns at the sample point after the accepting edge.
  task automatic applyStimulus(input int d, input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
    op_r       = op;
    data_r     = data;
    shamt_r    = sh;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  task automatic collectResult(input int d, input int first_cyc, output int lat,
                               output logic [31:0] res, output int busy_cycles, output int overlaps);
    int cyc = first_cyc;
    lat = -1; res = '0; busy_cycles = 0; overlaps = 0;
    while (cyc <= 64) begin
      if (busy_v[d] && done_v[d]) overlaps++;
      if (busy_v[d]) busy_cycles++;
      if (done_v[d]) begin
        lat = cyc;
        res = res_v[d];
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic runVector(input int d, input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh,
                           input logic [31:0] exp_res, input int exp_lat, input string tag);
    int lat, bc, ov;
    logic [31:0] res;
    applyStimulus(d, op, data, sh);
    collectResult(d, 1, lat, res, bc, ov);
    checkOutput({tag, " result"}, res, exp_res);
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " busy cycles"}, 32'(bc), 32'(exp_lat - 1));
    checkOutput({tag, " busy/done overlap"}, 32'(ov), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, " done width"}, {31'b0, done_v[d]}, 32'd0);
    checkOutput({tag, " result hold"}, res_v[d], exp_res);
  endtask

  initial begin
    int lat, bc, ov, dcount;
    logic [31:0] res;
    vectors = 0; miscompares = 0;
    reset = 1'b1; start_v = '0; op_r = '0; data_r = '0; shamt_r = '0;

    table_v[0]  = '{0, 2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 2};
    table_v[1]  = '{0, 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 4};
    table_v[2]  = '{0, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 4};
    table_v[3]  = '{1, 2'b11, 32'h0000_000F, 5'd4,  32'hF000_0000, 1};
    table_v[4]  = '{1, 2'b11, 32'h0000_000F, 5'd31, 32'h0000_001E, 8};
    table_v[5]  = '{0, 2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
    table_v[6]  = '{1, 2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
    table_v[7]  = '{2, 2'b00, 32'h0000_0003, 5'd2,  32'h0000_000C, 1};
    table_v[8]  = '{2, 2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 1};
    table_v[9]  = '{0, 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 31};
    table_v[10] = '{1, 2'b01, 32'hF000_0000, 5'd5,  32'h0780_0000, 2};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset result d%0d", d), res_v[d], 32'd0);
      checkOutput($sformatf("reset busy d%0d", d), {31'b0, busy_v[d]}, 32'd0);
      checkOutput($sformatf("reset done d%0d", d), {31'b0, done_v[d]}, 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      runVector(table_v[i].d, table_v[i].op, table_v[i].data, table_v[i].sh,
                table_v[i].exp_res, table_v[i].exp_lat, $sformatf("vec%0d", i));

    // A start arriving mid-shift must not disturb the running operation.
    applyStimulus(0, 2'b00, 32'h1, 5'd8);
    @(posedge clk); #1;
    op_r = 2'b01; data_r = 32'hFFFF_0000; shamt_r = 5'd1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    collectResult(0, 3, lat, res, bc, ov);
    checkOutput("ignored start result", res, 32'h0000_0100);
    checkOutput("ignored start latency", 32'(lat), 32'd8);
    @(posedge clk); #1;

    // Back-to-back: a start presented during the done cycle is taken at once.
    applyStimulus(0, 2'b00, 32'h1, 5'd2);
    collectResult(0, 1, lat, res, bc, ov);
    checkOutput("b2b first result", res, 32'h0000_0004);
    checkOutput("b2b first latency", 32'(lat), 32'd2);
    applyStimulus(0, 2'b01, 32'h0000_0080, 5'd3);
    checkOutput("b2b busy after accept", {31'b0, busy_v[0]}, 32'd1);
    checkOutput("b2b done after accept", {31'b0, done_v[0]}, 32'd0);
    collectResult(0, 1, lat, res, bc, ov);
    checkOutput("b2b second result", res, 32'h0000_0010);
    checkOutput("b2b second latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of a long shift abandons it without a done pulse.
    applyStimulus(0, 2'b00, 32'h1, 5'd20);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("busy before reset", {31'b0, busy_v[0]}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("reset busy", {31'b0, busy_v[0]}, 32'd0);
    checkOutput("reset done", {31'b0, done_v[0]}, 32'd0);
    checkOutput("reset result", res_v[0], 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_v[0]) dcount++;
    end
    checkOutput("no done after reset", 32'(dcount), 32'd0);
    runVector(0, 2'b00, 32'h1, 5'd20, 32'h0010_0000, 20, "post-reset");

    for (int i = 0; i < 40; i++) begin
      int          d  = int'($urandom_range(0, 2));
      logic [1:0]  o  = 2'($urandom_range(0, 3));
      logic [31:0] x  = $urandom;
      int          s  = int'($urandom_range(0, 31));
      runVector(d, o, x, 5'(s), refResult(o, x, s), refLatency(s, stepOf(d)),
                $sformatf("rand%0d d%0d op%0d sh%0d", i, d, o, s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
